// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a synchronous FIFO, draining frames back-to-back.
// Define UART_TX_PARITY_EN for an even-parity bit and a two-bit stop phase.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int ADDR_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   FULL    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic       push;
    logic       pop;
    logic       last;
    logic       stop_done;
    logic [7:0] head;

    assign in_ready   = (count_q != FULL);
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];
    assign last       = (cnt_q == CNT_MAX);
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;

`ifdef UART_TX_PARITY_EN
    // Second stop bit is tracked in bit_idx so the stop phase spans two bits.
    assign stop_done = bit_idx_q[0];
`else
    assign stop_done = 1'b1;
`endif

    // FIFO storage: written on accepted push; flushed only by pointer reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointer and occupancy update from push/pop strobes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Serializer FSM: start, 8 data bits LSB first, [parity], stop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = last ? '0 : cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            S_START: begin
                if (last) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (last) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (last) begin
                    tx_d      = 1'b1;
                    bit_idx_d = 3'd0;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (last && !stop_done) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end else if (last) begin
                    bit_idx_d = 3'd0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset also flushes the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, corner sequences, random traffic
// checked against a queue-based line model.
module tb_uart_tx_fifo;

    localparam int CPB    = 4;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic [ADDR_W:0]   fifo_count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: pending bytes and the remaining line levels of the
    // frame in flight, one entry per clock cycle.
    logic [7:0] mq[$];
    logic       line[$];
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_bit(input logic b, input int n);
        for (int i = 0; i < n; i++) line.push_back(b);
    endtask

    task automatic load_frame(input logic [7:0] b);
        add_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) add_bit(b[i], CPB);
`ifdef UART_TX_PARITY_EN
        add_bit(^b, CPB);
        add_bit(1'b1, 2 * CPB);
`else
        add_bit(1'b1, CPB);
`endif
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
        logic acc;
        logic cons;
        if (r) begin
            mq.delete();
            line.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else begin
            acc  = v && (mq.size() != DEPTH);
            cons = 1'b0;
            if (line.size() == 0 && mq.size() != 0) load_frame(mq.pop_front());
            if (acc) mq.push_back(d);
            if (line.size() != 0) begin
                m_tx = line.pop_front();
                cons = 1'b1;
            end else begin
                m_tx = 1'b1;
            end
            m_busy = cons || (mq.size() != 0);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        reset    = r;
        in_valid = v;
        in_data  = d;
        @(posedge clock);
        model_edge(r, v, d);
        #1;
        chk("tx", int'(tx), int'(m_tx));
        chk("busy", int'(busy), int'(m_busy));
        chk("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
        chk("fifo_count", int'(fifo_count), mq.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        int         n;
        logic       e_tx;
        logic       e_busy;
        logic       e_rdy;
        int         e_cnt;
    } vec_t;

    vec_t tab[$];
    int   acc_cnt;
    int   rv;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Single 0xA5 frame: start, 1,0,1,0,0,1,0,1, [parity], stop, idle.
        tab.push_back('{1'b1, 8'hA5, 1,   1'b1, 1'b1, 1'b1, 1});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b0, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b1, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b0, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b1, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b0, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b0, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b1, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b0, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, CPB, 1'b1, 1'b1, 1'b1, 0});
`ifdef UART_TX_PARITY_EN
        tab.push_back('{1'b0, 8'h00, CPB, 1'b0, 1'b1, 1'b1, 0});
        tab.push_back('{1'b0, 8'h00, 2 * CPB, 1'b1, 1'b1, 1'b1, 0});
`else
        tab.push_back('{1'b0, 8'h00, CPB, 1'b1, 1'b1, 1'b1, 0});
`endif
        tab.push_back('{1'b0, 8'h00, 3,   1'b1, 1'b0, 1'b1, 0});

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_count", int'(fifo_count), 0);

        idle(50);

        foreach (tab[k]) begin
            for (int i = 0; i < tab[k].n; i++) begin
                step(1'b0, tab[k].v, tab[k].d);
                chk($sformatf("tab%0d_tx", k), int'(tx), int'(tab[k].e_tx));
                chk($sformatf("tab%0d_busy", k), int'(busy), int'(tab[k].e_busy));
                chk($sformatf("tab%0d_rdy", k), int'(in_ready), int'(tab[k].e_rdy));
                chk($sformatf("tab%0d_cnt", k), int'(fifo_count), tab[k].e_cnt);
            end
        end

        // Three back-to-back bytes; gaps are checked cycle by cycle by the model.
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h3C);
        chk("b2b_count", int'(fifo_count), 2);
        idle(14 * CPB * 3);
        chk("b2b_idle", int'(busy), 0);

        // Burst of 20 pushes from idle: 16 fill plus one popped at once.
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) acc_cnt++;
            step(1'b0, 1'b1, 8'(8'h10 + i));
        end
        chk("burst_full", int'(in_ready), 0);
        chk("burst_accepted", acc_cnt, DEPTH + 1);
        idle(14 * CPB * (DEPTH + 2));
        chk("burst_drained", int'(busy), 0);

        // Reset during data bit 3 of 0x55 with five more bytes queued.
        step(1'b0, 1'b1, 8'h55);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i));
        idle(CPB * 4 + 1 - 6 + 2);
        step(1'b1, 1'b0, 8'h00);
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_busy", int'(busy), 0);
        idle(100);
        chk("midrst_quiet", int'(tx), 1);

`ifdef UART_TX_PARITY_EN
        step(1'b0, 1'b1, 8'h07);
        idle(14 * CPB);
        step(1'b0, 1'b1, 8'h03);
        idle(14 * CPB);
`endif

        // Random traffic: sparse pushes, bursts, occasional reset.
        for (int i = 0; i < 4000; i++) begin
            rv = int'($urandom_range(0, 999));
            if (rv == 0) begin
                step(1'b1, 1'b0, 8'h00);
            end else if (i % 600 < 40) begin
                step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            end else begin
                step(1'b0, 1'(rv < 40), 8'($urandom));
            end
        end
        idle(14 * CPB * (DEPTH + 2));
        chk("final_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
